alut_age_scrubber: RTL and testbench

// - Downstream of the ALUT APB register bank. Executes the table commands it issues on command[1:0]
//   (one-cycle pulse): 2'b01 = invalidate aged entries, 2'b10 = invalidate all entries.
// - Walks every address-table entry via a single-port synchronous RAM interface. Invalidates the

---
 rtl/alut_age_scrubber.sv | 142 ++++++++++++++
 tb/tb_alut_age_scrubber.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alut_age_scrubber.sv
// Address-table scrubber: runs the invalidate-aged / invalidate-all commands from the register
// bank by walking every entry through a single-port synchronous RAM.
module alut_age_scrubber #(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned AW          = 4
) (
  input  logic          pclk,
  input  logic          p_reset,
  input  logic [1:0]    command,
  input  logic [31:0]   curr_time,
  input  logic [31:0]   best_bfr_age,
  input  logic          add_check_active,
  input  logic [82:0]   mem_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [82:0]   mem_wdata,
  output logic          age_check_active,
  output logic          inval_in_prog,
  output logic [47:0]   lst_inv_addr_cmd,
  output logic [1:0]    lst_inv_port_cmd
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRd   = 3'd1;
  localparam logic [2:0] StWt   = 3'd2;
  localparam logic [2:0] StChk  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [1:0] OpAged = 2'b01;
  localparam logic [1:0] OpAll  = 2'b10;

  localparam logic [AW-1:0] LastIdx = AW'(NUM_ENTRIES - 1);

  logic [2:0]    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] index_q, index_d;
  logic          inval_q, inval_d;
  logic [47:0]   lst_addr_q, lst_addr_d;
  logic [1:0]    lst_port_q, lst_port_d;

  logic          entry_valid;
  logic [1:0]    entry_port;
  logic [47:0]   entry_addr;
  logic [31:0]   entry_tstamp;
  logic [31:0]   entry_age;
  logic          entry_aged;
  logic          rd_go;
  logic          hit;

  assign entry_valid  = mem_rdata[82];
  assign entry_port   = mem_rdata[81:80];
  assign entry_addr   = mem_rdata[79:32];
  assign entry_tstamp = mem_rdata[31:0];

  // Modulo subtraction keeps the age correct across a curr_time wrap.
  assign entry_age  = curr_time - entry_tstamp;
  assign entry_aged = entry_age > best_bfr_age;

  // The checker can only pre-empt us before a read is issued; RD->WT->CHK never stalls.
  assign rd_go = (state_q == StRd) && !add_check_active;
  assign hit   = (state_q == StChk) && entry_valid && ((op_q == OpAll) || entry_aged);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    index_d    = index_q;
    inval_d    = inval_q;
    lst_addr_d = lst_addr_q;
    lst_port_d = lst_port_q;

    case (state_q)
      StIdle: begin
        if ((command == OpAged) || (command == OpAll)) begin
          op_d    = command;
          index_d = '0;
          inval_d = 1'b1;
          state_d = StRd;
        end
      end
      StRd: begin
        if (rd_go) begin
          state_d = StWt;
        end
      end
      StWt: begin
        state_d = StChk;
      end
      StChk: begin
        if (hit) begin
          lst_addr_d = entry_addr;
          lst_port_d = entry_port;
        end
        if (index_q == LastIdx) begin
          state_d = StDone;
        end else begin
          index_d = index_q + AW'(1);
          state_d = StRd;
        end
      end
      StDone: begin
        inval_d = 1'b0;
        state_d = StIdle;
      end
      default: begin
        inval_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      state_q    <= StIdle;
      op_q       <= 2'b00;
      index_q    <= '0;
      inval_q    <= 1'b0;
      lst_addr_q <= '0;
      lst_port_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      index_q    <= index_d;
      inval_q    <= inval_d;
      lst_addr_q <= lst_addr_d;
      lst_port_q <= lst_port_d;
    end
  end

  // Strobes are decoded from state, so an asynchronous reset drops them in the same cycle.
  always_comb begin
    mem_rd           = rd_go;
    mem_wr           = hit;
    mem_addr         = (rd_go || hit) ? index_q : '0;
    mem_wdata        = hit ? {1'b0, mem_rdata[81:0]} : '0;
    age_check_active = rd_go || (state_q == StWt) || (state_q == StChk);
    inval_in_prog    = inval_q;
    lst_inv_addr_cmd = lst_addr_q;
    lst_inv_port_cmd = lst_port_q;
  end

endmodule

// File: tb/tb_alut_age_scrubber.sv
// Directed self-checking bench for alut_age_scrubber with a behavioural single-port table RAM.
module tb_alut_age_scrubber;

  logic        pclk;
  logic        p_reset;
  logic [1:0]  command;
  logic [31:0] curr_time;
  logic [31:0] best_bfr_age;
  logic        add_check_active;
  logic [82:0] mem_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [3:0]  mem_addr;
  logic [82:0] mem_wdata;
  logic        age_check_active;
  logic        inval_in_prog;
  logic [47:0] lst_inv_addr_cmd;
  logic [1:0]  lst_inv_port_cmd;

  alut_age_scrubber #(
    .NUM_ENTRIES(16),
    .AW         (4)
  ) dut (
    .pclk            (pclk),
    .p_reset         (p_reset),
    .command         (command),
    .curr_time       (curr_time),
    .best_bfr_age    (best_bfr_age),
    .add_check_active(add_check_active),
    .mem_rdata       (mem_rdata),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .age_check_active(age_check_active),
    .inval_in_prog   (inval_in_prog),
    .lst_inv_addr_cmd(lst_inv_addr_cmd),
    .lst_inv_port_cmd(lst_inv_port_cmd)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Table RAM model: 1-cycle read latency, data held until the next read.
  logic [82:0] mem [16];
  logic [82:0] img [16];
  logic        load_all = 1'b0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          both_cnt = 0;
  int          last_wr_idx = -1;

  initial mem_rdata = '0;

  always @(posedge pclk) begin
    if (load_all) begin
      for (int k = 0; k < 16; k++) mem[k] <= img[k];
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) begin
      wr_cnt      <= wr_cnt + 1;
      last_wr_idx <= int'(mem_addr);
    end
    if (mem_rd) rd_cnt <= rd_cnt + 1;
    if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [82:0] ent(input logic v, input logic [1:0] p, input logic [47:0] a,
                                      input logic [31:0] ts);
    return {v, p, a, ts};
  endfunction

  task automatic load_image();
    load_all = 1'b1;
    tick();
    load_all = 1'b0;
  endtask

  task automatic clear_image();
    for (int k = 0; k < 16; k++) img[k] = '0;
  endtask

  task automatic wait_done(input string tag, inout int lat);
    while (inval_in_prog && lat < 400) begin
      tick();
      lat++;
    end
    check(tag, 128'(inval_in_prog), 128'(0));
  endtask

  task automatic run_cmd(input logic [1:0] cmd, output int lat);
    command = cmd;
    tick();
    command = 2'b00;
    lat = 1;
    wait_done("scan_finished", lat);
  endtask

  int w0;
  int r0;
  int lat;
  int stall_bad;
  logic any_valid;

  initial begin
    p_reset          = 1'b1;
    command          = 2'b00;
    curr_time        = '0;
    best_bfr_age     = '0;
    add_check_active = 1'b0;
    clear_image();

    #2;
    check("rst_strobes", 128'({mem_rd, mem_wr, age_check_active, inval_in_prog}), 128'(0));
    check("rst_mem_bus", 128'({mem_addr, mem_wdata}), 128'(0));
    check("rst_lst_inv", 128'({lst_inv_addr_cmd, lst_inv_port_cmd}), 128'(0));
    tick();
    tick();
    p_reset = 1'b0;
    load_image();
    check("idle_after_rst", 128'({mem_rd, mem_wr, age_check_active, inval_in_prog}), 128'(0));

    // Reserved command encoding does nothing.
    r0 = rd_cnt;
    command = 2'b11;
    tick();
    command = 2'b00;
    tick();
    check("cmd11_ignored", 128'({inval_in_prog, 32'(rd_cnt - r0)}), 128'(0));

    // Age boundary: age 50 is not > 50; age 51 is.
    clear_image();
    img[3] = ent(1'b1, 2'd2, 48'h0000_1111_2222, 32'd100);
    load_image();
    curr_time    = 32'd150;
    best_bfr_age = 32'd50;
    w0 = wr_cnt;
    run_cmd(2'b01, lat);
    check("age_eq_latency", 128'(lat), 128'(50));
    check("age_eq_no_write", 128'(wr_cnt - w0), 128'(0));
    check("age_eq_still_valid", 128'(mem[3][82]), 128'(1));
    check("age_eq_lst_untouched", 128'(lst_inv_addr_cmd), 128'(0));
    curr_time = 32'd151;
    w0 = wr_cnt;
    run_cmd(2'b01, lat);
    check("age_gt_one_write", 128'(wr_cnt - w0), 128'(1));
    check("age_gt_write_idx", 128'(last_wr_idx), 128'(3));
    check("age_gt_entry", 128'(mem[3]), 128'(ent(1'b0, 2'd2, 48'h0000_1111_2222, 32'd100)));
    check("age_gt_lst_addr", 128'(lst_inv_addr_cmd), 128'(48'h0000_1111_2222));
    check("age_gt_lst_port", 128'(lst_inv_port_cmd), 128'(2));

    // Time wrap: entry 7 is 32 old, entry 8 is 31 old, limit 31.
    clear_image();
    img[7] = ent(1'b1, 2'd1, 48'hABCD_EF01_2345, 32'hffff_fff0);
    img[8] = ent(1'b1, 2'd3, 48'h5555_6666_7777, 32'hffff_fff1);
    load_image();
    curr_time    = 32'h10;
    best_bfr_age = 32'd31;
    w0 = wr_cnt;
    run_cmd(2'b01, lat);
    check("wrap_one_write", 128'(wr_cnt - w0), 128'(1));
    check("wrap_write_idx", 128'(last_wr_idx), 128'(7));
    check("wrap_entry7_invalid", 128'(mem[7][82]), 128'(0));
    check("wrap_entry8_valid", 128'(mem[8][82]), 128'(1));
    check("wrap_lst", 128'({lst_inv_addr_cmd, lst_inv_port_cmd}), 128'({48'hABCD_EF01_2345, 2'd1}));

    // Clear all ignores age entirely.
    clear_image();
    img[0]  = ent(1'b1, 2'd0, 48'h0000_0000_0A00, 32'd5);
    img[2]  = ent(1'b1, 2'd1, 48'h0000_0000_0A02, 32'd6);
    img[5]  = ent(1'b1, 2'd2, 48'h0000_0000_0A05, 32'd7);
    img[9]  = ent(1'b1, 2'd3, 48'h0000_0000_0A09, 32'd8);
    img[12] = ent(1'b1, 2'd1, 48'h1234_5678_9ABC, 32'd9);
    img[13] = ent(1'b0, 2'd2, 48'hFFFF_FFFF_FFFF, 32'd9);
    load_image();
    curr_time    = 32'd10;
    best_bfr_age = 32'hffff_ffff;
    w0 = wr_cnt;
    run_cmd(2'b10, lat);
    check("clr_latency", 128'(lat), 128'(50));
    check("clr_five_writes", 128'(wr_cnt - w0), 128'(5));
    check("clr_lst", 128'({lst_inv_addr_cmd, lst_inv_port_cmd}), 128'({48'h1234_5678_9ABC, 2'd1}));
    any_valid = 1'b0;
    for (int k = 0; k < 16; k++) any_valid = any_valid | mem[k][82];
    check("clr_none_valid", 128'(any_valid), 128'(0));

    // Commands during a scan are dropped; all-ones limit never hits.
    for (int k = 0; k < 16; k++) img[k] = ent(1'b1, 2'(k), 48'(k), 32'd0);
    load_image();
    curr_time    = 32'hffff_ffff;
    best_bfr_age = 32'hffff_ffff;
    w0 = wr_cnt;
    r0 = rd_cnt;
    command = 2'b01;
    tick();
    command = 2'b00;
    lat = 1;
    for (int k = 0; k < 9; k++) begin
      tick();
      lat++;
    end
    command = 2'b01;
    tick();
    lat++;
    command = 2'b10;
    tick();
    lat++;
    command = 2'b00;
    wait_done("busy_scan_finished", lat);
    check("busy_latency", 128'(lat), 128'(50));
    check("busy_one_scan_reads", 128'(rd_cnt - r0), 128'(16));
    check("busy_no_writes", 128'(wr_cnt - w0), 128'(0));
    for (int k = 0; k < 5; k++) tick();
    check("busy_not_queued", 128'({inval_in_prog, 32'(rd_cnt - r0)}), 128'({1'b0, 32'd16}));

    // Contention: checker holds the table for 7 cycles in RD, then again across WT/CHK.
    clear_image();
    img[0] = ent(1'b1, 2'd3, 48'h0BAD_F00D_0001, 32'd0);
    load_image();
    curr_time    = 32'd1000;
    best_bfr_age = 32'd10;
    w0 = wr_cnt;
    command = 2'b01;
    tick();
    command = 2'b00;
    add_check_active = 1'b1;
    #1;
    stall_bad = 0;
    for (int k = 0; k < 7; k++) begin
      if (mem_rd || age_check_active) stall_bad++;
      tick();
    end
    check("cont_stalled", 128'(stall_bad), 128'(0));
    add_check_active = 1'b0;
    #1;
    check("cont_resume_rd", 128'({mem_rd, mem_addr, age_check_active}), 128'({1'b1, 4'd0, 1'b1}));
    tick();
    add_check_active = 1'b1;
    #1;
    check("cont_wt_held", 128'({age_check_active, mem_rd, mem_wr}), 128'({1'b1, 1'b0, 1'b0}));
    tick();
    check("cont_chk_write", 128'({mem_wr, mem_addr, age_check_active}), 128'({1'b1, 4'd0, 1'b1}));
    tick();
    check("cont_rd1_yield", 128'({mem_rd, age_check_active}), 128'(0));
    add_check_active = 1'b0;
    lat = 0;
    wait_done("cont_scan_finished", lat);
    check("cont_one_write", 128'(wr_cnt - w0), 128'(1));
    check("cont_lst", 128'({lst_inv_addr_cmd, lst_inv_port_cmd}), 128'({48'h0BAD_F00D_0001, 2'd3}));

    // Reset in the middle of a clear-all scan.
    for (int k = 0; k < 16; k++) img[k] = ent(1'b1, 2'(k), 48'(k + 256), 32'd0);
    load_image();
    command = 2'b10;
    tick();
    command = 2'b00;
    for (int k = 0; k < 19; k++) tick();
    check("mid_lst_before_rst", 128'(lst_inv_addr_cmd), 128'(48'd261));
    #3;
    p_reset = 1'b1;
    #1;
    check("mid_rst_strobes", 128'({mem_rd, mem_wr, age_check_active, inval_in_prog}), 128'(0));
    check("mid_rst_bus", 128'({mem_addr, mem_wdata}), 128'(0));
    check("mid_rst_lst", 128'({lst_inv_addr_cmd, lst_inv_port_cmd}), 128'(0));
    tick();
    tick();
    p_reset = 1'b0;
    w0 = wr_cnt;
    for (int k = 0; k < 10; k++) tick();
    check("mid_no_write_after", 128'({inval_in_prog, 32'(wr_cnt - w0)}), 128'(0));
    check("mid_done_entries", 128'({mem[0][82], mem[5][82], mem[6][82]}), 128'(3'b001));
    w0 = wr_cnt;
    command = 2'b10;
    tick();
    command = 2'b00;
    check("mid_restart_idx0", 128'({mem_rd, mem_addr}), 128'({1'b1, 4'd0}));
    lat = 1;
    wait_done("mid_rescan_finished", lat);
    check("mid_rescan_latency", 128'(lat), 128'(50));
    check("mid_rescan_writes", 128'(wr_cnt - w0), 128'(10));
    check("mid_rescan_lst", 128'({lst_inv_addr_cmd, lst_inv_port_cmd}), 128'({48'd271, 2'd3}));

    check("rd_wr_exclusive", 128'(both_cnt), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
